// File: rtl/traffic_pkg.sv
// Shared constants for the traffic controller's request inputs.
// One request_debouncer is instantiated per entry of req_idx_e.
package traffic_pkg;

    // Default number of stable cycles before a new input level is accepted
    localparam int DEFAULT_DEBOUNCE_CYCLES = 32'sd16;

    // Default width of the diagnostic press counter
    localparam int PRESS_W = 32'sd8;

    // Number of request inputs on the controller
    localparam int NUM_REQ = 32'sd4;

    // Request indices used when building the per-input debouncer array
    typedef enum logic [1:0] {
        PED_NS = 2'd0,
        PED_EW = 2'd1,
        CAR_NS = 2'd2,
        CAR_EW = 2'd3
    } req_idx_e;

endpackage

// File: rtl/request_debouncer_debounce_filter.sv
// Stability filter: a new level on sync_in is accepted only after it has
// persisted for DEBOUNCE_CYCLES consecutive samples. Any sample equal to the
// current debounced level restarts the count.
module debounce_filter #(
    parameter int DEBOUNCE_CYCLES = traffic_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic db_level,
    output logic accept
);

    // Counter width is derived from the stability length, never overridden
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("debounce_filter: DEBOUNCE_CYCLES must be 2 or more");
    end

    logic [CNT_W-1:0] cnt_r;
    logic             db_level_r;

    // The level flips on this edge: input still differs and the count is full
    assign accept   = (sync_in != db_level_r) && (cnt_r == LAST_C);
    assign db_level = db_level_r;

    // Stability counter and debounced level register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CNT_W{1'b0}};
            db_level_r <= 1'b0;
        end else if (sync_in == db_level_r) begin
            cnt_r      <= {CNT_W{1'b0}};
            db_level_r <= db_level_r;
        end else if (accept) begin
            cnt_r      <= {CNT_W{1'b0}};
            db_level_r <= sync_in;
        end else begin
            cnt_r      <= cnt_r + CNT_W'(1'b1);
            db_level_r <= db_level_r;
        end
    end

endmodule

// File: rtl/request_debouncer.sv
// Request debouncer for one pedestrian-button or car-sensor input.
// Produces a clean level, one-cycle edge pulses, a request latch held until
// the traffic FSM acknowledges it, and a saturating press counter.
module request_debouncer #(
    parameter int DEBOUNCE_CYCLES = traffic_pkg::DEFAULT_DEBOUNCE_CYCLES,
    parameter int PRESS_W         = traffic_pkg::PRESS_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync_in,
    input  logic               req_ack,
    input  logic               cnt_clr,
    output logic               db_level,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic               req_pending,
    output logic [PRESS_W-1:0] press_count
);

    logic               db_level_s;
    logic               accept_s;
    logic               rise_s;
    logic               fall_s;
    logic               rise_pulse_r;
    logic               fall_pulse_r;
    logic               req_pending_r;
    logic [PRESS_W-1:0] press_count_r;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .sync_in (sync_in),
        .db_level(db_level_s),
        .accept  (accept_s)
    );

    // The filter accepts the new sample level, so its value gives the edge type
    assign rise_s = accept_s & sync_in;
    assign fall_s = accept_s & ~sync_in;

    assign db_level    = db_level_s;
    assign rise_pulse  = rise_pulse_r;
    assign fall_pulse  = fall_pulse_r;
    assign req_pending = req_pending_r;
    assign press_count = press_count_r;

    // Edge pulses, request latch and press counter, all updated with db_level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pulse_r  <= 1'b0;
            fall_pulse_r  <= 1'b0;
            req_pending_r <= 1'b0;
            press_count_r <= {PRESS_W{1'b0}};
        end else begin
            rise_pulse_r <= rise_s;
            fall_pulse_r <= fall_s;

            // A new press wins over a simultaneous acknowledge so it is not lost
            if (rise_s) begin
                req_pending_r <= 1'b1;
            end else if (req_ack) begin
                req_pending_r <= 1'b0;
            end else begin
                req_pending_r <= req_pending_r;
            end

            // Clear has priority, but a press on the same edge still counts once
            if (cnt_clr) begin
                press_count_r <= rise_s ? PRESS_W'(1'b1) : {PRESS_W{1'b0}};
            end else if (rise_s && (press_count_r != {PRESS_W{1'b1}})) begin
                press_count_r <= press_count_r + PRESS_W'(1'b1);
            end else begin
                press_count_r <= press_count_r;
            end
        end
    end

endmodule

// File: doc/request_debouncer.md
Name: request_debouncer

Overview:
- Sits directly downstream of the 2-flop input synchronizer on each pedestrian-button and car-sensor input of the traffic controller.
- Filters contact bounce on the already-synchronized level and produces a clean level plus one-cycle edge pulses.
- Holds a latched request until the traffic-light FSM acknowledges it, and keeps a saturating press counter for diagnostics.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a new input level must persist before it is accepted. Legal range is 2 or more; elaboration error otherwise.
- CNT_W, $clog2(DEBOUNCE_CYCLES): width of the stability counter. Derived; not to be overridden.
- PRESS_W, 8: width of the press counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sync_in  in  1  synchronized raw input; must come from the synchronizer, never from a pad
- req_ack  in  1  one-cycle acknowledge from the traffic FSM
- cnt_clr  in  1  synchronous clear of press_count
- db_level  out  1  debounced level
- rise_pulse  out  1  one-cycle pulse when db_level goes 0->1
- fall_pulse  out  1  one-cycle pulse when db_level goes 1->0
- req_pending  out  1  latched request
- press_count  out  PRESS_W  saturating count of accepted presses

Behaviour:
- Reset (rst_n=0, asynchronous): stability counter=0, db_level=0, rise_pulse=0, fall_pulse=0, req_pending=0, press_count=0. All outputs are registered.
- Stability counter, at each clk edge:
  - If sync_in==db_level: counter<=0.
  - Else if counter==DEBOUNCE_CYCLES-1: db_level<=sync_in and counter<=0.
  - Else: counter<=counter+1.
- Acceptance latency: if sync_in differs from db_level at edges k..k+N-1 (N=DEBOUNCE_CYCLES), db_level changes at edge k+N-1.
- Glitch rejection: any single sample equal to db_level restarts the count. A pulse of N-1 cycles or shorter never propagates.
- Edge pulses:
  - rise_pulse and fall_pulse are registered and assert at the same edge db_level changes.
  - High for exactly one cycle; never both high together.
- req_pending:
  - Set at the edge rise_pulse asserts.
  - Cleared at an edge where req_ack=1 and no rise is occurring.
  - Rise and req_ack in the same cycle: req_pending stays 1, so the new press is not lost.
  - req_ack while req_pending=0: no effect.
  - A second rise while pending: stays 1, no queuing.
- press_count:
  - Increments on each rise and saturates at all-ones.
  - cnt_clr=1 forces 0. cnt_clr with a simultaneous rise gives 1.
- Reset asserted mid-count or mid-pulse: everything returns to the reset values immediately. After deassertion, an input held at 1 needs a full N cycles before a rise is reported.
- Width rules: counter compares against DEBOUNCE_CYCLES-1 truncated to CNT_W. Counter never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package (traffic_pkg): DEFAULT_DEBOUNCE_CYCLES, PRESS_W, and the request-index constants (PED_NS, PED_EW, CAR_NS, CAR_EW) used when instantiating one debouncer per input.
- One natural sub-module: debounce_filter. It contains the stability counter and db_level, and outputs db_level.
- The top level adds the edge pulses, req_pending and press_count.

Test Plan:
- Reset check: N=4; hold rst_n=0 with sync_in=1, then release -> all outputs stay 0 for cycles 0-2; db_level=1 and rise_pulse=1 at the 4th edge after release; req_pending=1 and press_count=1 from the next cycle.
- Bounce rejection: N=4, db_level=0; drive sync_in 1,1,1,0,1,1,0 -> db_level stays 0, no pulses. Then hold 1 for 4 cycles -> exactly one rise_pulse.
- Release: from db_level=1, drive sync_in=0 for 4 cycles -> fall_pulse for exactly one cycle; req_pending unchanged.
- Handshake: req_pending=1, pulse req_ack -> req_pending=0 next cycle. Align req_ack with a rise_pulse edge -> req_pending stays 1. req_ack while idle -> no change.
- Saturation and clear: PRESS_W=2, 5 debounced presses -> press_count sequence 1,2,3,3,3. cnt_clr together with a rise -> press_count=1.
- Mid-operation reset: assert rst_n=0 for 1 cycle after 2 differing samples -> counter and outputs return to 0; a full 4 cycles are needed afterwards before a rise.
